// File: rtl/display_scheduler.sv
// Round-robin scheduler that shares a three-digit seven-segment display among four
// 8-bit sources, converting each snapshot to BCD with a serial double-dabble engine.

module display_scheduler #(
    parameter int DWELL = 50_000_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  src_valid,
    input  logic [31:0] src_data,
    input  logic        hold,
    output logic [6:0]  hex0,
    output logic [6:0]  hex1,
    output logic [6:0]  hex2,
    output logic [6:0]  hex3,
    output logic [1:0]  cur_src,
    output logic        busy
);

    localparam int DW = $clog2(DWELL + 1);
    localparam logic [DW-1:0] DWELL_LAST = DW'(DWELL - 1);
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_SELECT  = 2'd1,
        S_CONVERT = 2'd2,
        S_SHOW    = 2'd3
    } state_t;

    state_t          state_r;
    state_t          state_s;
    logic [1:0]      cur_src_r;
    logic [7:0]      bin_r;
    logic [11:0]     bcd_r;
    logic [2:0]      bit_cnt_r;
    logic [DW-1:0]   dwell_r;
    logic [6:0]      hex0_r;
    logic [6:0]      hex1_r;
    logic [6:0]      hex2_r;
    logic [6:0]      hex3_r;
    logic            busy_r;

    logic [1:0]      pick_s;
    logic            pick_ok_s;
    logic [11:0]     bcd_adj_s;
    logic [11:0]     bcd_shift_s;
    logic [7:0]      bin_shift_s;

    function automatic logic [6:0] seg7(input logic [3:0] digit);
        logic [6:0] seg;
        case (digit)
            4'd0:    seg = 7'b1000000;
            4'd1:    seg = 7'b1111001;
            4'd2:    seg = 7'b0100100;
            4'd3:    seg = 7'b0110000;
            4'd4:    seg = 7'b0011001;
            4'd5:    seg = 7'b0010010;
            4'd6:    seg = 7'b0000010;
            4'd7:    seg = 7'b1111000;
            4'd8:    seg = 7'b0000000;
            4'd9:    seg = 7'b0010000;
            default: seg = 7'b1111111;
        endcase
        return seg;
    endfunction

    function automatic logic [3:0] add3(input logic [3:0] nib);
        return (nib >= 4'd5) ? (nib + 4'd3) : nib;
    endfunction

    // Source pick: keep the current one under hold, else search cur+1 .. cur+4.
    always_comb begin
        pick_s    = cur_src_r;
        pick_ok_s = 1'b0;
        if (hold && src_valid[cur_src_r]) begin
            pick_s    = cur_src_r;
            pick_ok_s = 1'b1;
        end else begin
            for (int k = 1; k <= 4; k++) begin
                if (!pick_ok_s && src_valid[cur_src_r + 2'(k)]) begin
                    pick_s    = cur_src_r + 2'(k);
                    pick_ok_s = 1'b1;
                end else begin
                    pick_s    = pick_s;
                    pick_ok_s = pick_ok_s;
                end
            end
        end
    end

    // One double-dabble step: correct every nibble, then shift {bcd, bin} left.
    always_comb begin
        bcd_adj_s   = {add3(bcd_r[11:8]), add3(bcd_r[7:4]), add3(bcd_r[3:0])};
        bcd_shift_s = {bcd_adj_s[10:0], bin_r[7]};
        bin_shift_s = {bin_r[6:0], 1'b0};
    end

    // Next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            S_IDLE: begin
                if (|src_valid) state_s = S_SELECT;
                else            state_s = S_IDLE;
            end
            S_SELECT: begin
                if (pick_ok_s) state_s = S_CONVERT;
                else           state_s = S_IDLE;
            end
            S_CONVERT: begin
                if (bit_cnt_r == 3'd7) state_s = S_SHOW;
                else                   state_s = S_CONVERT;
            end
            S_SHOW: begin
                if (dwell_r == DWELL_LAST) state_s = S_SELECT;
                else                       state_s = S_SHOW;
            end
            default: state_s = S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state_r <= S_IDLE;
        else     state_r <= state_s;
    end

    // Datapath: snapshot, serial conversion, dwell timing and registered display.
    always_ff @(posedge clk) begin
        if (rst) begin
            cur_src_r <= 2'd3;
            bin_r     <= 8'd0;
            bcd_r     <= 12'd0;
            bit_cnt_r <= 3'd0;
            dwell_r   <= '0;
            hex0_r    <= SEG_BLANK;
            hex1_r    <= SEG_BLANK;
            hex2_r    <= SEG_BLANK;
            hex3_r    <= SEG_BLANK;
            busy_r    <= 1'b0;
        end else begin
            busy_r <= (state_s == S_CONVERT);
            case (state_r)
                S_IDLE: begin
                    dwell_r <= '0;
                end
                S_SELECT: begin
                    if (pick_ok_s) begin
                        cur_src_r <= pick_s;
                        bin_r     <= src_data[{pick_s, 3'b000} +: 8];
                        bcd_r     <= 12'd0;
                        bit_cnt_r <= 3'd0;
                    end else begin
                        hex0_r <= SEG_BLANK;
                        hex1_r <= SEG_BLANK;
                        hex2_r <= SEG_BLANK;
                        hex3_r <= SEG_BLANK;
                    end
                end
                S_CONVERT: begin
                    bcd_r     <= bcd_shift_s;
                    bin_r     <= bin_shift_s;
                    bit_cnt_r <= bit_cnt_r + 3'd1;
                    if (bit_cnt_r == 3'd7) begin
                        hex0_r  <= seg7(bcd_shift_s[3:0]);
                        hex1_r  <= seg7(bcd_shift_s[7:4]);
                        hex2_r  <= seg7(bcd_shift_s[11:8]);
                        hex3_r  <= seg7({2'b00, cur_src_r});
                        dwell_r <= '0;
                    end else begin
                        dwell_r <= dwell_r;
                    end
                end
                S_SHOW: begin
                    if (dwell_r == DWELL_LAST) dwell_r <= '0;
                    else                       dwell_r <= dwell_r + DW'(1);
                end
                default: begin
                    dwell_r <= '0;
                end
            endcase
        end
    end

    assign hex0    = hex0_r;
    assign hex1    = hex1_r;
    assign hex2    = hex2_r;
    assign hex3    = hex3_r;
    assign cur_src = cur_src_r;
    assign busy    = busy_r;

    display_scheduler_checker u_checker (
        .clk   (clk),
        .rst   (rst),
        .state (state_r),
        .busy  (busy_r),
        .bcd   (bcd_r)
    );

endmodule

// Invariants of the scheduler: busy tracks CONVERT, BCD nibbles stay decimal.
module display_scheduler_checker (
    input logic        clk,
    input logic        rst,
    input logic [1:0]  state,
    input logic        busy,
    input logic [11:0] bcd
);

    localparam logic [1:0] ENC_CONVERT = 2'd2;

    a_busy_is_convert: assert property (@(posedge clk) disable iff (rst)
        busy == (state == ENC_CONVERT));

    a_bcd_decimal: assert property (@(posedge clk) disable iff (rst)
        (state == ENC_CONVERT) |-> ((bcd[3:0] <= 4'd9) && (bcd[7:4] <= 4'd9) && (bcd[11:8] <= 4'd9)));

endmodule

// File: tb/tb_display_scheduler.sv
// Randomized and directed bench for display_scheduler, checked every cycle against
// a period-position reference model that derives digits with decimal arithmetic.

module tb_display_scheduler;

    localparam int DWELL = 4;
    localparam int PERIOD = 9 + DWELL;
    localparam logic [6:0] BLANK = 7'b1111111;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  src_valid = 4'd0;
    logic [31:0] src_data = 32'd0;
    logic        hold = 1'b0;
    logic [6:0]  hex0, hex1, hex2, hex3;
    logic [1:0]  cur_src;
    logic        busy;

    int checks = 0;
    int errors = 0;

    logic [6:0] seg_tab [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                                 7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};

    // Reference model: active flag plus position within one period
    // (0 = selection, 1..8 = conversion, 9..8+DWELL = dwell).
    bit         m_active = 1'b0;
    int         m_t = 0;
    int         m_cur = 3;
    int         m_val = 0;
    logic [6:0] m_hex [4] = '{BLANK, BLANK, BLANK, BLANK};
    bit         m_busy = 1'b0;

    display_scheduler #(.DWELL(DWELL)) dut (
        .clk       (clk),
        .rst       (rst),
        .src_valid (src_valid),
        .src_data  (src_data),
        .hold      (hold),
        .hex0      (hex0),
        .hex1      (hex1),
        .hex2      (hex2),
        .hex3      (hex3),
        .cur_src   (cur_src),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input int unsigned obs, input int unsigned exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic blank_model();
        for (int i = 0; i < 4; i++) m_hex[i] = BLANK;
    endtask

    // Advance the model by one clock edge using the inputs currently applied.
    task automatic model_edge();
        int pick;
        if (rst) begin
            m_active = 1'b0;
            m_t = 0;
            m_cur = 3;
            blank_model();
        end else if (!m_active) begin
            if (src_valid != 4'd0) begin
                m_active = 1'b1;
                m_t = 0;
            end
        end else if (m_t == 0) begin
            pick = -1;
            if (hold && src_valid[m_cur]) pick = m_cur;
            else begin
                for (int k = 1; k <= 4; k++)
                    if (pick < 0 && src_valid[(m_cur + k) % 4]) pick = (m_cur + k) % 4;
            end
            if (pick < 0) begin
                m_active = 1'b0;
                blank_model();
            end else begin
                m_cur = pick;
                m_val = int'((src_data >> (8 * pick)) & 32'hFF);
                m_t = 1;
            end
        end else if (m_t < 8) begin
            m_t++;
        end else if (m_t == 8) begin
            m_hex[0] = seg_tab[m_val % 10];
            m_hex[1] = seg_tab[(m_val / 10) % 10];
            m_hex[2] = seg_tab[m_val / 100];
            m_hex[3] = seg_tab[m_cur];
            m_t = 9;
        end else if (m_t < 8 + DWELL) begin
            m_t++;
        end else begin
            m_t = 0;
        end
        m_busy = m_active && (m_t >= 1) && (m_t <= 8);
    endtask

    task automatic step();
        model_edge();
        @(posedge clk);
        @(negedge clk);
        check_val("hex0", hex0, m_hex[0]);
        check_val("hex1", hex1, m_hex[1]);
        check_val("hex2", hex2, m_hex[2]);
        check_val("hex3", hex3, m_hex[3]);
        check_val("busy", busy, m_busy);
        check_val("cur_src", cur_src, m_cur);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic set_data(input int idx, input int val);
        src_data[8*idx +: 8] = 8'(val);
    endtask

    initial begin
        int last_rise;
        int shown2;
        bit prev_busy;
        bit reached;

        // Reset held with nothing valid.
        rst = 1'b1;
        run(20);
        check_val("reset_hex0", hex0, BLANK);
        check_val("reset_hex3", hex3, BLANK);
        check_val("reset_cur", cur_src, 3);

        // Single source at 255: digits ten edges after valid is first sampled.
        rst = 1'b0;
        set_data(0, 255);
        src_valid = 4'b0001;
        run(10);
        check_val("s255_hex2", hex2, 7'b0100100);
        check_val("s255_hex1", hex1, 7'b0010010);
        check_val("s255_hex0", hex0, 7'b0010010);
        check_val("s255_hex3", hex3, 7'b1000000);
        check_val("s255_cur", cur_src, 0);
        last_rise = -1;
        prev_busy = busy;
        for (int i = 0; i < 45; i++) begin
            step();
            if (busy && !prev_busy) begin
                if (last_rise >= 0) check_val("period", i - last_rise, PERIOD);
                last_rise = i;
            end
            prev_busy = busy;
        end

        // Three valid sources; source 2 must never be shown.
        set_data(0, 7); set_data(1, 100); set_data(2, 55); set_data(3, 42);
        src_valid = 4'b1011;
        shown2 = 0;
        for (int i = 0; i < 70; i++) begin
            step();
            if (hex3 == seg_tab[2]) shown2++;
        end
        check_val("src2_never_shown", shown2, 0);

        // Hold on source 1 while its value changes during the dwell.
        reached = 1'b0;
        for (int i = 0; i < 60 && !reached; i++) begin
            step();
            reached = m_active && (m_t >= 9) && (m_cur == 1);
        end
        check_val("reach_s1_show", reached, 1);
        hold = 1'b1;
        set_data(1, 199);
        run(2 * PERIOD);
        check_val("hold_cur", cur_src, 1);
        check_val("hold_hex2", hex2, 7'b1111001);
        check_val("hold_hex1", hex1, 7'b0010000);
        check_val("hold_hex0", hex0, 7'b0010000);
        hold = 1'b0;

        // All sources drop mid-dwell.
        reached = 1'b0;
        for (int i = 0; i < 40 && !reached; i++) begin
            step();
            reached = m_active && (m_t == 10);
        end
        check_val("reach_show", reached, 1);
        src_valid = 4'b0000;
        run(20);
        check_val("drop_hex0", hex0, BLANK);
        check_val("drop_hex3", hex3, BLANK);

        // Reset on the 4th conversion cycle.
        set_data(0, 123);
        src_valid = 4'b0001;
        reached = 1'b0;
        for (int i = 0; i < 40 && !reached; i++) begin
            step();
            reached = m_active && (m_t == 4);
        end
        check_val("reach_conv4", reached, 1);
        rst = 1'b1;
        step();
        check_val("midrst_hex1", hex1, BLANK);
        check_val("midrst_busy", busy, 0);
        rst = 1'b0;
        src_valid = 4'b0101;
        run(10);
        check_val("after_rst_cur", cur_src, 0);
        check_val("after_rst_hex3", hex3, seg_tab[0]);
        check_val("after_rst_hex2", hex2, seg_tab[1]);

        // Randomized traffic.
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 7) == 0) src_valid = 4'($urandom_range(0, 15));
            src_data = $urandom;
            hold = ($urandom_range(0, 3) == 0);
            rst = ($urandom_range(0, 199) == 0);
            step();
        end
        rst = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
